// File: rtl/audio_clkgen.sv
// audio_clkgen: phase-locked I2S MCLK/SCLK/LRCK generator with clk-domain frame_start/bit_tick strobes
// Defining AUDIO_CLKGEN_FRAME_CNT_EN adds a 32-bit frame_cnt output.
module audio_clkgen #(
  parameter int MCLK_HALF = 4,
  parameter int BITS_PER_CH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic [1:0] mode,
  output logic mclk,
  output logic sclk,
  output logic lrck,
  output logic frame_start,
  output logic bit_tick,
  output logic [$clog2(2*BITS_PER_CH)-1:0] bit_idx
`ifdef AUDIO_CLKGEN_FRAME_CNT_EN
  ,
  output logic [31:0] frame_cnt
`endif
);
  localparam int IW = $clog2(2*BITS_PER_CH);
  localparam int PW = MCLK_HALF > 1 ? $clog2(MCLK_HALF) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(MCLK_HALF - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(2*BITS_PER_CH - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [9:0] s_q, s_d, ratio_q, ratio_d, s_last;
  logic mclk_q, mclk_d, sclk_q, sclk_d, lrck_q, lrck_d;
  logic frame_start_q, frame_start_d, bit_tick_q, bit_tick_d;
  logic [IW-1:0] bit_idx_q, bit_idx_d;
  logic half, swrap, fall, wrap;
  function automatic logic [9:0] ratio_of(input logic [1:0] m);
    return m == 2'd1 ? 10'd384 : m == 2'd2 ? 10'd512 : 10'd256;
  endfunction
  // One counter chain p -> s -> bit_idx keeps mclk, sclk and lrck phase-locked.
  always_comb begin
    s_last = (ratio_q >> IW) - 10'd1;
    half = p_q == P_LAST;
    swrap = half && s_q == s_last;
    fall = swrap && sclk_q;
    wrap = fall && bit_idx_q == IDX_LAST;
    state_d = state_q;
    ratio_d = ratio_q;
    p_d = '0;
    s_d = '0;
    mclk_d = 1'b0;
    sclk_d = 1'b0;
    bit_idx_d = '0;
    frame_start_d = 1'b0;
    bit_tick_d = 1'b0;
    if (state_q == IDLE) begin
      if (en) begin
        state_d = RUN;
        ratio_d = ratio_of(mode);
        frame_start_d = 1'b1;
      end
    end else if (!en) begin
      state_d = IDLE;
    end else begin
      p_d = half ? '0 : p_q + 1'b1;
      s_d = swrap ? '0 : half ? s_q + 10'd1 : s_q;
      mclk_d = mclk_q ^ half;
      sclk_d = sclk_q ^ swrap;
      bit_idx_d = wrap ? '0 : bit_idx_q + IW'(fall);
      bit_tick_d = fall;
      frame_start_d = wrap;
      ratio_d = wrap ? ratio_of(mode) : ratio_q;
    end
    lrck_d = bit_idx_d[IW-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ratio_q <= 10'd256;
      p_q <= '0;
      s_q <= '0;
      mclk_q <= 1'b0;
      sclk_q <= 1'b0;
      lrck_q <= 1'b0;
      bit_idx_q <= '0;
      frame_start_q <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ratio_q <= ratio_d;
      p_q <= p_d;
      s_q <= s_d;
      mclk_q <= mclk_d;
      sclk_q <= sclk_d;
      lrck_q <= lrck_d;
      bit_idx_q <= bit_idx_d;
      frame_start_q <= frame_start_d;
      bit_tick_q <= bit_tick_d;
    end
  end
  assign mclk = mclk_q;
  assign sclk = sclk_q;
  assign lrck = lrck_q;
  assign frame_start = frame_start_q;
  assign bit_tick = bit_tick_q;
  assign bit_idx = bit_idx_q;
`ifdef AUDIO_CLKGEN_FRAME_CNT_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;
  // The frame_start on entering RUN is not counted; only boundary wraps are.
  always_comb frame_cnt_d = (state_q == RUN && en) ? frame_cnt_q + 32'(wrap) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else frame_cnt_q <= frame_cnt_d;
  end
  assign frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_audio_clkgen.sv
// tb_audio_clkgen: scoreboard bench for audio_clkgen timing, mode latching, stop/restart and reset.
module tb_audio_clkgen;
  localparam int MH = 4;
  localparam int BPC = 32;
  localparam int IW = $clog2(2*BPC);
  localparam longint FS_VEC = longint'(2) << IW;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic mclk, sclk, lrck, frame_start, bit_tick;
  logic [IW-1:0] bit_idx;
`ifdef AUDIO_CLKGEN_FRAME_CNT_EN
  logic [31:0] frame_cnt;
`endif
  int checks = 0;
  int failures = 0;
  typedef struct {string tag; longint v;} exp_t;
  exp_t sb[$];
  audio_clkgen #(.MCLK_HALF(MH), .BITS_PER_CH(BPC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .mode(mode),
    .mclk(mclk),
    .sclk(sclk),
    .lrck(lrck),
    .frame_start(frame_start),
    .bit_tick(bit_tick),
    .bit_idx(bit_idx)
`ifdef AUDIO_CLKGEN_FRAME_CNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic push(input string tag, input longint v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic sb_check(input longint got);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
      return;
    end
    e = sb.pop_front();
    check(e.tag, got, e.v);
  endtask
  function automatic longint vec();
    return longint'({mclk, sclk, lrck, frame_start, bit_tick, bit_idx});
  endfunction
  function automatic logic sig(input int sel);
    return sel == 0 ? mclk : sel == 1 ? sclk : sel == 2 ? lrck : sel == 3 ? frame_start : bit_tick;
  endfunction
  task automatic wait_for(input int sel, input logic val, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sig(sel) !== val && n < 20000);
    if (sig(sel) !== val) check("wait_timeout", sel, -1);
  endtask
  task automatic wait_idx(input int idx);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (int'(bit_idx) != idx && n < 20000);
    if (int'(bit_idx) != idx) check("idx_timeout", bit_idx, idx);
  endtask
  task automatic period(input int sel, output int hi, output int per);
    int n, lo;
    wait_for(sel, 1'b0, n);
    wait_for(sel, 1'b1, n);
    wait_for(sel, 1'b0, hi);
    wait_for(sel, 1'b1, lo);
    per = hi + lo;
  endtask
  // Starts on a negedge where frame_start is high and runs to the next one.
  task automatic frame_run(input int sw_idx, input logic [1:0] sw_mode, output int len,
                           output int ticks, output int lr_at, output int lr_idx);
    len = 0;
    ticks = 0;
    lr_at = -1;
    lr_idx = -1;
    do begin
      @(negedge clk);
      len++;
      if (bit_tick) ticks++;
      if (lrck && lr_at < 0) begin
        lr_at = len;
        lr_idx = int'(bit_idx);
      end
      if (int'(bit_idx) == sw_idx) mode = sw_mode;
    end while (!frame_start && len < 20000);
    if (!frame_start) check("frame_timeout", len, -1);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, hi, per, len, ticks, lr_at, lr_idx;
    repeat (3) @(negedge clk);
    push("reset_out", 0);
    sb_check(vec());
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    push("idle_en0", 0);
    sb_check(vec());
    mode = 2'd0;
    en = 1'b1;
    push("start_fs", FS_VEC);
    push("mclk_first_rise", 4);
    push("mclk_hi", 4);
    push("mclk_per", 8);
    push("sclk_hi", 16);
    push("sclk_per", 32);
    @(negedge clk);
    sb_check(vec());
    wait_for(0, 1'b1, n);
    sb_check(n);
    period(0, hi, per);
    sb_check(hi);
    sb_check(per);
    period(1, hi, per);
    sb_check(hi);
    sb_check(per);
    wait_for(3, 1'b1, n);
    push("frame0_len", 2048);
    push("frame0_ticks", 64);
    push("lrck_rise_at", 1024);
    push("lrck_rise_idx", 32);
    push("fs_lrck_low", 0);
    frame_run(-1, 2'd0, len, ticks, lr_at, lr_idx);
    sb_check(len);
    sb_check(ticks);
    sb_check(lr_at);
    sb_check(lr_idx);
    sb_check(lrck);
    push("sw_frame_cur", 2048);
    push("sw_frame_next", 4096);
    frame_run(10, 2'd2, len, ticks, lr_at, lr_idx);
    sb_check(len);
    frame_run(-1, 2'd2, len, ticks, lr_at, lr_idx);
    sb_check(len);
    en = 1'b0;
    @(negedge clk);
    mode = 2'd1;
    en = 1'b1;
    push("m1_sclk_hi", 24);
    push("m1_sclk_per", 48);
    push("m1_frame", 3072);
    @(negedge clk);
    period(1, hi, per);
    sb_check(hi);
    sb_check(per);
    wait_for(3, 1'b1, n);
    frame_run(-1, 2'd1, len, ticks, lr_at, lr_idx);
    sb_check(len);
    en = 1'b0;
    @(negedge clk);
    mode = 2'd2;
    en = 1'b1;
    push("m2_sclk_hi", 32);
    push("m2_sclk_per", 64);
    push("m2_frame", 4096);
    @(negedge clk);
    period(1, hi, per);
    sb_check(hi);
    sb_check(per);
    wait_for(3, 1'b1, n);
    frame_run(-1, 2'd2, len, ticks, lr_at, lr_idx);
    sb_check(len);
    en = 1'b0;
    @(negedge clk);
    mode = 2'd0;
    en = 1'b1;
    @(negedge clk);
    wait_idx(40);
    en = 1'b0;
    push("stop_vec", 0);
    @(negedge clk);
    sb_check(vec());
    en = 1'b1;
    push("restart_fs", FS_VEC);
    push("restart_mclk", 4);
    @(negedge clk);
    sb_check(vec());
    wait_for(0, 1'b1, n);
    sb_check(n);
    wait_idx(20);
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    push("async_rst", 0);
    #1;
    sb_check(vec());
    @(negedge clk);
    rst_n = 1'b1;
    mode = 2'd3;
    repeat (3) @(negedge clk);
    push("post_rst_idle", 0);
    sb_check(vec());
    en = 1'b1;
    push("m3_fs", FS_VEC);
    push("m3_mclk", 4);
    push("m3_sclk_per", 32);
    push("m3_frame", 2048);
    @(negedge clk);
    sb_check(vec());
    wait_for(0, 1'b1, n);
    sb_check(n);
    period(1, hi, per);
    sb_check(per);
    wait_for(3, 1'b1, n);
    frame_run(-1, 2'd3, len, ticks, lr_at, lr_idx);
    sb_check(len);
`ifdef AUDIO_CLKGEN_FRAME_CNT_EN
    en = 1'b0;
    @(negedge clk);
    mode = 2'd0;
    en = 1'b1;
    push("fcnt_first", 0);
    push("fcnt_fifth", 4);
    @(negedge clk);
    sb_check(frame_cnt);
    repeat (4) wait_for(3, 1'b1, n);
    sb_check(frame_cnt);
`endif
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
